// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg: shared types and helpers for the FPU request arbiter.
//   arb_state_t : arbiter FSM states (ARB, HOLD, FLUSH)
//   STATUS_W    : width of the FPU status flags {NV,DZ,OF,UF,NX}
//   id_width()  : requester-ID width, at least one bit
package fpu_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

    localparam int unsigned STATUS_W = 5;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: pure combinational round-robin priority selector.
//   i_req       : request vector, one bit per requester
//   i_rr_ptr    : highest-priority requester index for this cycle
//   o_grant     : one-hot grant
//   o_grant_idx : index of the granted requester (0 when nothing granted)
//   o_any_grant : at least one request present
module rr_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any_grant
);

    localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(NUM_REQ);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Walk offsets 0..NUM_REQ-1 from the pointer; the sum is one bit wider
    // so the wrap-around can be done with a single conditional subtract.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, i_rr_ptr} + (ID_W + 1)'(i);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            w_idx = w_sum[ID_W-1:0];
            if (!o_any_grant && i_req[w_idx]) begin
                o_any_grant    = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one FPU between NUM_REQ requesters.
//   Requester side : req_valid/req_ready/req_operands/req_ctrl in,
//                    rsp_valid (one-hot)/rsp_ready/rsp_result/rsp_status out
//   FPU side       : fpu_in_valid/fpu_in_ready/fpu_operands/fpu_ctrl/fpu_tag/
//                    fpu_flush out, fpu_out_valid/fpu_out_ready/fpu_result/
//                    fpu_status/fpu_tag_o back
//   Control        : flush aborts all in-flight work
//   Observability  : outstanding (in-flight count), busy
// Round-robin grant on the input channel, requester ID carried on the FPU
// tag, results routed back by tag, in-flight ops bounded by a credit count.
module fpu_req_arbiter
    import fpu_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ         = 2,
    parameter  int unsigned DWIDTH          = 16,
    parameter  int unsigned NUM_OPERANDS    = 3,
    parameter  int unsigned CTRL_W          = 16,
    parameter  int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned ID_W            = id_width(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*NUM_OPERANDS*DWIDTH-1:0] req_operands,
    input  logic [NUM_REQ*CTRL_W-1:0]              req_ctrl,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    input  logic [NUM_REQ-1:0]                     rsp_ready,
    output logic [DWIDTH-1:0]                      rsp_result,
    output logic [STATUS_W-1:0]                    rsp_status,
    input  logic                                   flush,
    output logic                                   fpu_in_valid,
    input  logic                                   fpu_in_ready,
    output logic [NUM_OPERANDS*DWIDTH-1:0]         fpu_operands,
    output logic [CTRL_W-1:0]                      fpu_ctrl,
    output logic [ID_W-1:0]                        fpu_tag,
    output logic                                   fpu_flush,
    input  logic                                   fpu_out_valid,
    output logic                                   fpu_out_ready,
    input  logic [DWIDTH-1:0]                      fpu_result,
    input  logic [STATUS_W-1:0]                    fpu_status,
    input  logic [ID_W-1:0]                        fpu_tag_o,
    output logic [3:0]                             outstanding,
    output logic                                   busy
);

    localparam int unsigned   OPW    = NUM_OPERANDS * DWIDTH;
    localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [3:0]    MAX_W  = 4'(MAX_OUTSTANDING);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_t      r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_hold_id;
    logic [3:0]      r_outstanding;

    logic [OPW-1:0]    w_ops  [NUM_REQ];
    logic [CTRL_W-1:0] w_ctrl [NUM_REQ];

    logic [NUM_REQ-1:0] w_arb_req;
    logic [NUM_REQ-1:0] w_arb_grant;
    logic [ID_W-1:0]    w_arb_idx;
    logic               w_arb_any;
    logic               w_can_issue;
    logic [ID_W-1:0]    w_sel_id;
    logic [ID_W-1:0]    w_next_ptr;
    logic               w_in_hs;
    logic               w_out_hs;
    logic               w_tag_ok;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign w_ops[g]  = req_operands[g*OPW +: OPW];
        assign w_ctrl[g] = req_ctrl[g*CTRL_W +: CTRL_W];
    end

    // Credit check uses the registered count: a result returned this cycle
    // only frees its credit for the following cycle.
    assign w_can_issue = (r_outstanding < MAX_W);
    assign w_arb_req   = w_can_issue ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req       (w_arb_req),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx),
        .o_any_grant (w_arb_any)
    );

    assign w_sel_id   = (r_state == HOLD) ? r_hold_id : w_arb_idx;
    assign w_next_ptr = (w_sel_id == LAST_ID) ? '0 : w_sel_id + 1'b1;

    // Outputs are forced low while rst is held so nothing is issued or
    // signalled during reset, independent of the live request inputs.
    always_comb begin
        fpu_in_valid = 1'b0;
        if (!rst) begin
            case (r_state)
                ARB:     fpu_in_valid = w_arb_any;
                HOLD:    fpu_in_valid = 1'b1;
                default: fpu_in_valid = 1'b0;
            endcase
        end
    end

    assign w_in_hs      = fpu_in_valid && fpu_in_ready;
    assign fpu_operands = w_ops[w_sel_id];
    assign fpu_ctrl     = w_ctrl[w_sel_id];
    assign fpu_tag      = w_sel_id;
    assign fpu_flush    = !rst && (r_state == FLUSH);

    always_comb begin
        req_ready = '0;
        if (w_in_hs) begin
            req_ready[w_sel_id] = 1'b1;
        end
    end

    // Response routing. Out-of-range tags and anything arriving in FLUSH are
    // consumed without signalling any requester.
    assign w_tag_ok   = ({1'b0, fpu_tag_o} < NREQ_W);
    assign rsp_result = fpu_result;
    assign rsp_status = fpu_status;

    always_comb begin
        rsp_valid = '0;
        if (!rst && (r_state != FLUSH) && fpu_out_valid && w_tag_ok) begin
            rsp_valid[fpu_tag_o] = 1'b1;
        end
    end

    always_comb begin
        fpu_out_ready = 1'b1;
        if ((r_state != FLUSH) && w_tag_ok) begin
            fpu_out_ready = rsp_ready[fpu_tag_o];
        end
    end

    assign w_out_hs    = fpu_out_valid && fpu_out_ready && (r_state != FLUSH);
    assign outstanding = r_outstanding;
    assign busy        = (r_outstanding != 4'd0) || (r_state != ARB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ARB;
            r_rr_ptr      <= '0;
            r_hold_id     <= '0;
            r_outstanding <= '0;
        end else begin
            if (flush || (r_state == FLUSH)) begin
                r_outstanding <= '0;
            end else if (w_in_hs && !w_out_hs) begin
                r_outstanding <= r_outstanding + 4'd1;
            end else if (w_out_hs && !w_in_hs) begin
                r_outstanding <= r_outstanding - 4'd1;
            end

            if (w_in_hs) begin
                r_rr_ptr <= w_next_ptr;
            end

            case (r_state)
                ARB: begin
                    if (flush) begin
                        r_state <= FLUSH;
                    end else if (fpu_in_valid && !fpu_in_ready) begin
                        r_hold_id <= w_arb_idx;
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        r_state <= FLUSH;
                    end else if (fpu_in_ready) begin
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    a_hold_valid: assert property (@(posedge clk) disable iff (rst)
        ((r_state == HOLD) && !flush) |-> req_valid[r_hold_id])
        else $error("requester dropped req_valid while held");

    a_credit_ovf: assert property (@(posedge clk) disable iff (rst)
        (w_in_hs && !w_out_hs && !flush) |-> (r_outstanding != MAX_W))
        else $error("outstanding overflow");

    a_credit_udf: assert property (@(posedge clk) disable iff (rst)
        (w_out_hs && !w_in_hs && !flush) |-> (r_outstanding != 4'd0))
        else $error("outstanding underflow");

    a_tag_range: assert property (@(posedge clk) disable iff (rst)
        (fpu_out_valid && (r_state != FLUSH)) |-> w_tag_ok)
        else $error("result tag out of range");

endmodule

// File: tb/tb_fpu_req_arbiter.sv
module tb_fpu_req_arbiter;

    localparam int NR   = 2;
    localparam int DW   = 16;
    localparam int NO   = 3;
    localparam int CW   = 16;
    localparam int MAXO = 4;
    localparam int IDW  = 1;
    localparam int OPW  = NO * DW;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*OPW-1:0] req_operands;
    logic [NR*CW-1:0]  req_ctrl;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [DW-1:0]     rsp_result;
    logic [4:0]        rsp_status;
    logic              flush;
    logic              fpu_in_valid;
    logic              fpu_in_ready;
    logic [OPW-1:0]    fpu_operands;
    logic [CW-1:0]     fpu_ctrl;
    logic [IDW-1:0]    fpu_tag;
    logic              fpu_flush;
    logic              fpu_out_valid;
    logic              fpu_out_ready;
    logic [DW-1:0]     fpu_result;
    logic [4:0]        fpu_status;
    logic [IDW-1:0]    fpu_tag_o;
    logic [3:0]        outstanding;
    logic              busy;

    fpu_req_arbiter #(
        .NUM_REQ         (NR),
        .DWIDTH          (DW),
        .NUM_OPERANDS    (NO),
        .CTRL_W          (CW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operands  (req_operands),
        .req_ctrl      (req_ctrl),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_status    (rsp_status),
        .flush         (flush),
        .fpu_in_valid  (fpu_in_valid),
        .fpu_in_ready  (fpu_in_ready),
        .fpu_operands  (fpu_operands),
        .fpu_ctrl      (fpu_ctrl),
        .fpu_tag       (fpu_tag),
        .fpu_flush     (fpu_flush),
        .fpu_out_valid (fpu_out_valid),
        .fpu_out_ready (fpu_out_ready),
        .fpu_result    (fpu_result),
        .fpu_status    (fpu_status),
        .fpu_tag_o     (fpu_tag_o),
        .outstanding   (outstanding),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: next requester to favour, credits in use, ops held by
    // the FPU (tags, oldest first).
    int m_ptr = 0;
    int m_out = 0;
    int fpu_q[$];

    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[IDW'((ptr + k) % NR)]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [OPW-1:0] ops_of(input int id);
        return req_operands[id*OPW +: OPW];
    endfunction

    function automatic logic [CW-1:0] ctrl_of(input int id);
        return req_ctrl[id*CW +: CW];
    endfunction

    task automatic model_step(input bit ihs, input int itag, input bit ohs);
        if (ohs) begin
            void'(fpu_q.pop_front());
            m_out--;
        end
        if (ihs) begin
            fpu_q.push_back(itag);
            m_ptr = (itag + 1) % NR;
            m_out++;
        end
    endtask

    task automatic randomize_payloads();
        for (int i = 0; i < NR; i++) begin
            req_operands[i*OPW +: OPW] = {$urandom, $urandom};
            req_ctrl[i*CW +: CW]       = CW'($urandom);
        end
    endtask

    task automatic idle_inputs();
        req_valid     = '0;
        rsp_ready     = '0;
        flush         = 1'b0;
        fpu_in_ready  = 1'b0;
        fpu_out_valid = 1'b0;
        fpu_result    = '0;
        fpu_status    = '0;
        fpu_tag_o     = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && fpu_q.size() > 0; k++) begin
            req_valid     = '0;
            fpu_out_valid = 1'b1;
            fpu_tag_o     = IDW'(fpu_q[0]);
            fpu_result    = DW'($urandom);
            rsp_ready     = '1;
            #1;
            n_tests++;
            if (fpu_out_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_out_ready got %b want 1", fpu_out_ready);
            end
            model_step(0, 0, 1);
            @(negedge clk);
        end
        fpu_out_valid = 1'b0;
        rsp_ready     = '0;
        #1;
        n_tests++;
        if (outstanding !== 4'(m_out) || fpu_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_outstanding got %0d want %0d (queue %0d)", outstanding, m_out, fpu_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst           = 1'b1;
        req_valid     = '1;
        fpu_in_ready  = 1'b1;
        fpu_out_valid = 1'b1;
        rsp_ready     = '1;
        randomize_payloads();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (fpu_in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_valid got %b want 0", fpu_in_valid); end
        n_tests++;
        if (req_ready !== '0) begin n_fail++; $display("FAIL rst_req_ready got %b want 00", req_ready); end
        n_tests++;
        if (rsp_valid !== '0) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 00", rsp_valid); end
        n_tests++;
        if (fpu_flush !== 1'b0) begin n_fail++; $display("FAIL rst_fpu_flush got %b want 0", fpu_flush); end
        n_tests++;
        if (outstanding !== 4'd0) begin n_fail++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        idle_inputs();
        rst   = 1'b0;
        m_ptr = 0;
        m_out = 0;
        fpu_q.delete();
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int cnt[NR];
        int exp;
        bit ov;
        cnt[0] = 0;
        cnt[1] = 0;
        randomize_payloads();
        req_valid    = 2'b11;
        fpu_in_ready = 1'b1;
        rsp_ready    = 2'b11;
        for (int c = 0; c < 8; c++) begin
            ov            = (fpu_q.size() > 0);
            fpu_out_valid = ov;
            fpu_tag_o     = ov ? IDW'(fpu_q[0]) : '0;
            fpu_result    = DW'($urandom);
            exp           = c % 2;
            #1;
            n_tests++;
            if (fpu_in_valid !== 1'b1 || fpu_tag !== IDW'(exp)) begin
                n_fail++;
                $display("FAIL fair_grant cycle %0d got valid=%b tag=%0d want valid=1 tag=%0d", c, fpu_in_valid, fpu_tag, exp);
            end
            n_tests++;
            if (fpu_operands !== ops_of(exp)) begin
                n_fail++;
                $display("FAIL fair_payload cycle %0d got %h want %h", c, fpu_operands, ops_of(exp));
            end
            n_tests++;
            if (rsp_valid !== (ov ? NR'(1 << fpu_q[0]) : NR'(0))) begin
                n_fail++;
                $display("FAIL fair_rsp_valid cycle %0d got %b", c, rsp_valid);
            end
            if (req_ready[0] === 1'b1) cnt[0]++;
            if (req_ready[1] === 1'b1) cnt[1]++;
            model_step(1, exp, ov);
            @(negedge clk);
        end
        n_tests++;
        if (cnt[0] != 4 || cnt[1] != 4) begin
            n_fail++;
            $display("FAIL fair_counts got %0d/%0d want 4/4", cnt[0], cnt[1]);
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_backpressure();
        logic [OPW-1:0] p1;
        randomize_payloads();
        p1            = ops_of(1);
        fpu_out_valid = 1'b0;
        fpu_in_ready  = 1'b0;
        req_valid     = 2'b10;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) req_valid = 2'b11;
            #1;
            n_tests++;
            if (fpu_in_valid !== 1'b1 || fpu_tag !== 1'b1 || req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got valid=%b tag=%0d ready=%b want 1/1/00", c, fpu_in_valid, fpu_tag, req_ready);
            end
            n_tests++;
            if (fpu_operands !== p1) begin
                n_fail++;
                $display("FAIL bp_payload cycle %0d got %h want %h", c, fpu_operands, p1);
            end
            @(negedge clk);
        end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy got %b want 1", busy); end
        fpu_in_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 2'b10 || fpu_tag !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept1 got ready=%b tag=%0d want 10/1", req_ready, fpu_tag);
        end
        model_step(1, 1, 0);
        @(negedge clk);
        #1;
        n_tests++;
        if (req_ready !== 2'b01 || fpu_tag !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_then0 got ready=%b tag=%0d want 01/0", req_ready, fpu_tag);
        end
        model_step(1, 0, 0);
        @(negedge clk);
        req_valid    = '0;
        fpu_in_ready = 1'b0;
        drain();
    endtask

    task automatic test_credit();
        int acc;
        int g;
        int zi;
        acc = 0;
        randomize_payloads();
        req_valid     = 2'b11;
        fpu_in_ready  = 1'b1;
        fpu_out_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_tests++;
            if (fpu_in_valid !== (c < MAXO)) begin
                n_fail++;
                $display("FAIL credit_valid cycle %0d got %b want %b", c, fpu_in_valid, (c < MAXO));
            end
            if (c < MAXO) begin
                g = pick(req_valid, m_ptr);
                model_step(1, g, 0);
            end
            if (req_ready !== 2'b00) acc++;
            @(negedge clk);
        end
        n_tests++;
        if (acc != MAXO || outstanding !== 4'd4) begin
            n_fail++;
            $display("FAIL credit_full got accepts=%0d outstanding=%0d want 4/4", acc, outstanding);
        end
        // Return one op carrying tag 0.
        zi = -1;
        foreach (fpu_q[i]) if (zi < 0 && fpu_q[i] == 0) zi = i;
        fpu_out_valid = 1'b1;
        fpu_tag_o     = 1'b0;
        rsp_ready     = 2'b11;
        #1;
        n_tests++;
        if (fpu_in_valid !== 1'b0 || fpu_out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_return got in_valid=%b out_ready=%b want 0/1", fpu_in_valid, fpu_out_ready);
        end
        if (zi >= 0) fpu_q.delete(zi);
        m_out--;
        @(negedge clk);
        fpu_out_valid = 1'b0;
        #1;
        n_tests++;
        if (outstanding !== 4'd3 || fpu_in_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_reissue got outstanding=%0d in_valid=%b want 3/1", outstanding, fpu_in_valid);
        end
        g = pick(req_valid, m_ptr);
        model_step(1, g, 0);
        @(negedge clk);
        #1;
        n_tests++;
        if (outstanding !== 4'd4 || fpu_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_refull got outstanding=%0d in_valid=%b want 4/0", outstanding, fpu_in_valid);
        end
        req_valid = '0;
        @(negedge clk);
        drain();
    endtask

    task automatic test_routing();
        randomize_payloads();
        req_valid    = 2'b10;
        fpu_in_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL route_accept got %b want 10", req_ready); end
        model_step(1, 1, 0);
        @(negedge clk);
        req_valid     = '0;
        fpu_out_valid = 1'b1;
        fpu_tag_o     = 1'b1;
        fpu_result    = 16'h3C00;
        fpu_status    = 5'b00001;
        for (int c = 0; c < 2; c++) begin
            rsp_ready = (c == 0) ? 2'b00 : 2'b01;
            #1;
            n_tests++;
            if (rsp_valid !== 2'b10 || fpu_out_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL route_wait cycle %0d got rsp_valid=%b out_ready=%b want 10/0", c, rsp_valid, fpu_out_ready);
            end
            n_tests++;
            if (rsp_result !== 16'h3C00 || rsp_status !== 5'b00001) begin
                n_fail++;
                $display("FAIL route_data got %h/%b want 3c00/00001", rsp_result, rsp_status);
            end
            @(negedge clk);
        end
        n_tests++;
        if (outstanding !== 4'd1) begin n_fail++; $display("FAIL route_pending got %0d want 1", outstanding); end
        rsp_ready = 2'b10;
        #1;
        n_tests++;
        if (rsp_valid !== 2'b10 || fpu_out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL route_done got rsp_valid=%b out_ready=%b want 10/1", rsp_valid, fpu_out_ready);
        end
        model_step(0, 0, 1);
        @(negedge clk);
        fpu_out_valid = 1'b0;
        fpu_status    = '0;
        rsp_ready     = '0;
        #1;
        n_tests++;
        if (outstanding !== 4'(m_out) || rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL route_after got outstanding=%0d rsp_valid=%b want %0d/00", outstanding, rsp_valid, m_out);
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int g;
        randomize_payloads();
        req_valid    = 2'b11;
        fpu_in_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            g = pick(req_valid, m_ptr);
            model_step(1, g, 0);
            @(negedge clk);
        end
        fpu_out_valid = 1'b1;
        fpu_tag_o     = IDW'(fpu_q[0]);
        rsp_ready     = 2'b11;
        #1;
        n_tests++;
        if (outstanding !== 4'd2 || fpu_in_valid !== 1'b1 || fpu_out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_setup got outstanding=%0d in_valid=%b out_ready=%b want 2/1/1", outstanding, fpu_in_valid, fpu_out_ready);
        end
        g = pick(req_valid, m_ptr);
        model_step(1, g, 1);
        @(negedge clk);
        req_valid     = '0;
        fpu_out_valid = 1'b0;
        #1;
        n_tests++;
        if (outstanding !== 4'd2) begin n_fail++; $display("FAIL simul_count got %0d want 2", outstanding); end
        @(negedge clk);
        drain();
    endtask

    task automatic test_flush();
        int g;
        int saved_ptr;
        randomize_payloads();
        req_valid    = 2'b11;
        fpu_in_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            g = pick(req_valid, m_ptr);
            model_step(1, g, 0);
            @(negedge clk);
        end
        req_valid = '0;
        saved_ptr = m_ptr;
        flush     = 1'b1;
        #1;
        n_tests++;
        if (fpu_flush !== 1'b0 || outstanding !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_req got fpu_flush=%b outstanding=%0d want 0/3", fpu_flush, outstanding);
        end
        @(negedge clk);
        flush         = 1'b0;
        req_valid     = 2'b11;
        fpu_out_valid = 1'b1;
        fpu_tag_o     = 1'b0;
        rsp_ready     = 2'b11;
        #1;
        n_tests++;
        if (fpu_flush !== 1'b1 || outstanding !== 4'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pulse got fpu_flush=%b outstanding=%0d busy=%b want 1/0/1", fpu_flush, outstanding, busy);
        end
        n_tests++;
        if (fpu_in_valid !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_nogrant got in_valid=%b req_ready=%b want 0/00", fpu_in_valid, req_ready);
        end
        n_tests++;
        if (rsp_valid !== 2'b00 || fpu_out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_rsp got rsp_valid=%b out_ready=%b want 00/1", rsp_valid, fpu_out_ready);
        end
        fpu_q.delete();
        m_out = 0;
        @(negedge clk);
        fpu_out_valid = 1'b0;
        rsp_ready     = '0;
        #1;
        n_tests++;
        if (fpu_flush !== 1'b0 || busy !== 1'b0 || outstanding !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_after got fpu_flush=%b busy=%b outstanding=%0d want 0/0/0", fpu_flush, busy, outstanding);
        end
        n_tests++;
        if (fpu_in_valid !== 1'b1 || fpu_tag !== IDW'(saved_ptr)) begin
            n_fail++;
            $display("FAIL flush_ptr got valid=%b tag=%0d want 1/%0d", fpu_in_valid, fpu_tag, saved_ptr);
        end
        model_step(1, saved_ptr, 0);
        @(negedge clk);
        req_valid = '0;
        drain();
    endtask

    task automatic test_reset_hold();
        randomize_payloads();
        req_valid    = 2'b01;
        fpu_in_ready = 1'b1;
        #1;
        model_step(1, 0, 0);
        @(negedge clk);
        req_valid    = 2'b10;
        fpu_in_ready = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (fpu_in_valid !== 1'b1 || fpu_tag !== 1'b1 || outstanding !== 4'd1) begin
            n_fail++;
            $display("FAIL rsthold_setup got valid=%b tag=%0d outstanding=%0d want 1/1/1", fpu_in_valid, fpu_tag, outstanding);
        end
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        #1;
        n_tests++;
        if (fpu_in_valid !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00 || fpu_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL rsthold_outputs got %b/%b/%b/%b want 0/00/00/0", fpu_in_valid, req_ready, rsp_valid, fpu_flush);
        end
        n_tests++;
        if (outstanding !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rsthold_state got outstanding=%0d busy=%b want 0/0", outstanding, busy);
        end
        m_ptr = 0;
        m_out = 0;
        fpu_q.delete();
        @(negedge clk);
    endtask

    task automatic test_random();
        bit            pend[NR];
        bit            m_hold;
        int            m_hold_id;
        bit            out_hold;
        bit            ev, ihs, ohs;
        int            eid;
        int            c;
        logic [NR-1:0] pv;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        m_hold   = 1'b0;
        m_hold_id = 0;
        out_hold = 1'b0;
        c        = 0;
        while (c < 400 || pend[0] || pend[1] || fpu_q.size() > 0) begin
            if (c >= 600) begin
                n_tests++;
                n_fail++;
                $display("FAIL random_timeout pending=%b%b queue=%0d want all drained", pend[1], pend[0], fpu_q.size());
                break;
            end
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && c < 400 && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    req_operands[i*OPW +: OPW] = {$urandom, $urandom};
                    req_ctrl[i*CW +: CW]       = CW'($urandom);
                end
                pv[i] = pend[i];
            end
            req_valid    = pv;
            fpu_in_ready = ($urandom % 4 != 0);
            if (!out_hold) begin
                fpu_out_valid = (fpu_q.size() > 0) && ($urandom % 2 == 0);
                fpu_tag_o     = (fpu_q.size() > 0) ? IDW'(fpu_q[0]) : '0;
                fpu_result    = DW'($urandom);
                fpu_status    = 5'($urandom);
            end
            rsp_ready = NR'($urandom);
            #1;
            if (m_hold) begin
                ev  = 1'b1;
                eid = m_hold_id;
            end else begin
                eid = (m_out < MAXO) ? pick(pv, m_ptr) : -1;
                ev  = (eid >= 0);
            end
            n_tests++;
            if (fpu_in_valid !== ev) begin
                n_fail++;
                $display("FAIL rand_in_valid cycle %0d got %b want %b", c, fpu_in_valid, ev);
            end
            if (ev) begin
                n_tests++;
                if (fpu_tag !== IDW'(eid) || fpu_operands !== ops_of(eid) || fpu_ctrl !== ctrl_of(eid)) begin
                    n_fail++;
                    $display("FAIL rand_payload cycle %0d got tag=%0d want tag=%0d", c, fpu_tag, eid);
                end
            end
            ihs = ev && fpu_in_ready;
            n_tests++;
            if (req_ready !== (ihs ? NR'(1 << eid) : NR'(0))) begin
                n_fail++;
                $display("FAIL rand_req_ready cycle %0d got %b", c, req_ready);
            end
            n_tests++;
            if (outstanding !== 4'(m_out) || busy !== ((m_out != 0) || m_hold)) begin
                n_fail++;
                $display("FAIL rand_credit cycle %0d got outstanding=%0d busy=%b want %0d", c, outstanding, busy, m_out);
            end
            ohs = fpu_out_valid && rsp_ready[fpu_tag_o];
            n_tests++;
            if (rsp_valid !== (fpu_out_valid ? NR'(1 << fpu_q[0]) : NR'(0)) ||
                (fpu_out_valid && fpu_out_ready !== rsp_ready[fpu_tag_o])) begin
                n_fail++;
                $display("FAIL rand_rsp cycle %0d got rsp_valid=%b out_ready=%b", c, rsp_valid, fpu_out_ready);
            end
            if (ihs) begin
                pend[eid] = 1'b0;
                m_hold    = 1'b0;
            end else if (ev) begin
                m_hold    = 1'b1;
                m_hold_id = eid;
            end
            out_hold = fpu_out_valid && !ohs;
            model_step(ihs, eid, ohs);
            @(negedge clk);
            c++;
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst          = 1'b1;
        req_operands = '0;
        req_ctrl     = '0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_credit();
        test_routing();
        test_simultaneous();
        test_flush();
        test_reset_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
